// File: rtl/serial_adder_ctrl.sv
// Bit-serial ripple adder with a valid/ready operand port and a valid/ready result port.
// One full-adder slice is reused for WIDTH cycles, LSB first, then the result is held until taken.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (y & c) | (c & x);
    endfunction

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] a_sh_r, a_sh_nx_s;
    logic [WIDTH-1:0] b_sh_r, b_sh_nx_s;
    logic [WIDTH-1:0] acc_r, acc_nx_s;
    logic [WIDTH-1:0] sum_r, sum_nx_s;
    logic             cout_r, cout_nx_s;
    logic             carry_r, carry_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic             in_ready_r, out_valid_r, busy_r;
    logic             fa_s_s, fa_c_s;
    logic             accept_s, handshake_s;

    assign accept_s    = in_valid && in_ready_r;
    assign handshake_s = out_valid_r && out_ready;
    assign fa_s_s      = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
    assign fa_c_s      = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);

    // Next-state and datapath next values; operand registers shift right so bit 0 is always the current bit
    always_comb begin
        state_nx_s = state_r;
        a_sh_nx_s  = a_sh_r;
        b_sh_nx_s  = b_sh_r;
        acc_nx_s   = acc_r;
        sum_nx_s   = sum_r;
        cout_nx_s  = cout_r;
        carry_nx_s = carry_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_RUN;
                    a_sh_nx_s  = a;
                    b_sh_nx_s  = b;
                    acc_nx_s   = '0;
                    carry_nx_s = cin;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Sum bit enters at the MSB so the bit from step i lands at position i after WIDTH steps
                a_sh_nx_s  = a_sh_r >> 1'b1;
                b_sh_nx_s  = b_sh_r >> 1'b1;
                acc_nx_s   = acc_r >> 1'b1;
                acc_nx_s[WIDTH-1] = fa_s_s;
                carry_nx_s = fa_c_s;
                cnt_nx_s   = cnt_r + CNT_ONE;
                if (cnt_r == LAST_CNT) begin
                    state_nx_s = ST_DONE;
                    sum_nx_s   = acc_nx_s;
                    cout_nx_s  = fa_c_s;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (handshake_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            acc_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            a_sh_r      <= a_sh_nx_s;
            b_sh_r      <= b_sh_nx_s;
            acc_r       <= acc_nx_s;
            sum_r       <= sum_nx_s;
            cout_r      <= cout_nx_s;
            carry_r     <= carry_nx_s;
            cnt_r       <= cnt_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: an 8-bit instance checked every cycle against a transaction-level model,
// plus a 1-bit instance exercised through the full-adder truth table.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model of the 8-bit instance: an operation is in flight for 8 edges, then its
    // result is offered until taken; the last result persists until reset or the next completion.
    bit         m_ok = 1'b0;
    bit         m_inflight, m_valid;
    int         m_left;
    logic [8:0] m_res;
    logic [7:0] m_sum;
    logic       m_cout;
    logic [8:0] exp_q[$];
    int         n_acc = 0, n_hs = 0, n_drop = 0;

    // Inputs only change 2 time units after a rising edge, so at the falling edge they already
    // hold what the next rising edge will sample.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("in_ready", in_ready8, !(m_inflight || m_valid));
                chk("out_valid", out_valid8, m_valid);
                chk("busy", busy8, m_inflight || m_valid);
                chk("sum", sum8, m_sum);
                chk("cout", cout8, m_cout);
                if (out_valid8 && out_ready8 && !rst) begin
                    n_hs++;
                    chk("sb_pending", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("sb_result", {cout8, sum8}, e);
                    end
                end
            end
            if (rst) begin
                n_drop += exp_q.size();
                exp_q.delete();
                m_inflight = 1'b0;
                m_valid    = 1'b0;
                m_left     = 0;
                m_sum      = 8'h00;
                m_cout     = 1'b0;
                m_ok       = 1'b1;
            end else if (m_valid) begin
                if (out_ready8) m_valid = 1'b0;
            end else if (m_inflight) begin
                m_left--;
                if (m_left == 0) begin
                    m_inflight      = 1'b0;
                    m_valid         = 1'b1;
                    {m_cout, m_sum} = m_res;
                end
            end else if (in_valid8) begin
                m_res = 9'(a8) + 9'(b8) + 9'(cin8);
                exp_q.push_back(m_res);
                n_acc++;
                m_inflight = 1'b1;
                m_left     = 8;
            end
        end
    end

    // Waits for out_valid on the 8-bit instance, checking busy and the edge count since the start
    task automatic wait_out8(input string nm, input int exp_k);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk({nm, "_busy"}, busy8, 1'b1);
            if (out_valid8) break;
        end
        chk({nm, "_latency"}, k, exp_k);
    endtask

    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                           input logic [7:0] es, input logic ec, input string nm);
        @(posedge clk); #2;
        chk({nm, "_in_ready"}, in_ready8, 1'b1);
        a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #2;
        in_valid8 = 1'b0; a8 = ~ta; b8 = 8'h00; cin8 = ~tc;
        chk({nm, "_busy_run"}, busy8, 1'b1);
        wait_out8(nm, 8);
        chk({nm, "_sum"}, sum8, es);
        chk({nm, "_cout"}, cout8, ec);
    endtask

    int fa_tt[8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        chk("rst_in_ready8", in_ready8, 1'b1);
        chk("rst_out_valid8", out_valid8, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_sum8", sum8, 8'h00);
        chk("rst_cout8", cout8, 1'b0);
        chk("rst_in_ready1", in_ready1, 1'b1);
        chk("rst_out_valid1", out_valid1, 1'b0);
        chk("rst_busy1", busy1, 1'b0);

        run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_01");
        run_op8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "5a_a5_c1");
        run_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "12_34");

        // Backpressure: result held while out_ready is low and new operands are offered
        @(posedge clk); #2;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #2;
        in_valid8 = 1'b0;
        wait_out8("bp", 8);
        for (int i = 0; i < 5; i++) begin
            #1;
            in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid8, 1'b1);
            chk("bp_sum", sum8, 8'h30);
            chk("bp_cout", cout8, 1'b0);
            chk("bp_in_ready", in_ready8, 1'b0);
        end
        #1;
        out_ready8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_in_ready", in_ready8, 1'b1);
        chk("bp_hs_out_valid", out_valid8, 1'b0);
        chk("bp_hs_busy", busy8, 1'b0);
        @(posedge clk); #2;
        in_valid8 = 1'b0;
        wait_out8("bp_next", 8);
        chk("bp_next_sum", sum8, 8'h04);
        chk("bp_next_cout", cout8, 1'b0);

        // Reset sampled on the third RUN edge discards the operation
        @(posedge clk); #2;
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #2;
        in_valid8 = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_in_ready", in_ready8, 1'b1);
        chk("mrst_out_valid", out_valid8, 1'b0);
        chk("mrst_sum", sum8, 8'h00);
        chk("mrst_cout", cout8, 1'b0);
        chk("mrst_busy", busy8, 1'b0);
        #1 rst = 1'b0;
        run_op8(8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, "after_rst");

        // WIDTH=1 instance: full-adder truth table, one RUN cycle each
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            chk("w1_in_ready", in_ready1, 1'b1);
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; in_valid1 = 1'b1;
            @(posedge clk); #2;
            in_valid1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            chk("w1_busy", busy1, 1'b1);
            for (k = 1; k <= 5; k++) begin
                @(posedge clk); #1;
                if (out_valid1) break;
            end
            chk("w1_latency", k, 1);
            chk("w1_table", {cout1, sum1}, fa_tt[i]);
            chk("w1_arith", {cout1, sum1}, i[2] + i[1] + i[0]);
        end

        // Random back-to-back traffic with random backpressure
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #2;
            in_valid8  = 1'($urandom_range(0, 1));
            out_ready8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
        @(posedge clk); #2;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("sb_drained", exp_q.size(), 0);
        chk("sb_accounting", n_hs, n_acc - n_drop);
        chk("sb_enough_ops", n_acc >= 30, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is WIDTH >= 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result sum.
REQ-012 The block SHALL have port cout, output, 1 bit: the result carry-out.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-014 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder slice per cycle: s = x^y^c, c' = xy|yc|cx.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE: in_ready=1, out_valid=0.
REQ-017 In RUN and DONE: in_ready=0.
REQ-018 An accept SHALL occur when in_valid && in_ready at a rising edge.
REQ-019 On accept: latch a and b into shift registers, load the carry flop with cin, clear the bit counter to 0, and go to RUN.
REQ-020 Inputs a, b and cin SHALL be sampled only at the accept edge; later changes have no effect.
REQ-021 Each RUN edge SHALL add bit[count] of A and B with the carry flop, shift the sum bit into the result register at position count, update the carry flop, and increment count.
REQ-022 The edge in RUN where count == WIDTH-1 SHALL go to DONE; out_valid rises exactly WIDTH edges after the accept edge.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap during RUN.
REQ-024 In DONE: out_valid=1, sum holds the full result, and cout equals the final carry flop value.
REQ-025 sum, cout and out_valid SHALL remain stable until handshake completion.
REQ-026 out_valid && out_ready at an edge SHALL return the FSM to IDLE; in_ready rises the cycle after that edge, so there is no same-cycle re-accept.
REQ-027 The output handshake is complete only at that edge; out_ready asserted outside DONE SHALL be ignored.
REQ-028 in_valid asserted outside IDLE SHALL be ignored; no operand is queued.
REQ-029 sum and cout SHALL hold their last result after returning to IDLE until the next DONE.
REQ-030 For WIDTH=1, RUN SHALL last exactly one cycle.
REQ-031 Throughput SHALL be one addition per WIDTH+2 cycles maximum (accept, WIDTH RUN edges, DONE handshake).

Reset
REQ-032 rst=1 at an edge SHALL force: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0, carry flop=0, shift registers=0.
REQ-033 rst SHALL take priority over any simultaneous accept or handshake.
REQ-034 rst asserted mid-RUN or in DONE SHALL discard the in-flight operation with no out_valid pulse.

Verification
REQ-035 The bench SHALL cover WIDTH=8: a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid high 8 edges after accept, sum=0x00, cout=1, busy high throughout.
REQ-036 The bench SHALL cover WIDTH=8: a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1; then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-037 The bench SHALL cover backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> sum/cout/out_valid stable, in_ready=0, and no second accept until one cycle after the handshake.
REQ-038 The bench SHALL cover reset mid-RUN: assert rst at the 3rd RUN edge -> next cycle in_ready=1, out_valid=0, sum=0, cout=0, busy=0; a subsequent operation completes correctly.
REQ-039 The bench SHALL cover WIDTH=1, all 8 {a,b,cin} combinations -> {cout,sum} matches the full-adder truth table, each result after exactly 1 RUN cycle.
REQ-040 The bench SHALL cover random back-to-back operations with random out_ready -> every result equals a+b+cin from a reference model, with no lost or duplicated results.
